// File: rtl/periph_arb_pkg.sv
// Shared definitions for the peripheral register-bus arbiter: FSM encoding,
// default abort limit and the round-robin pointer helper.
package periph_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd255;

  // Index following idx in an n-entry ring.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by every requester and the
// peripheral-side decoder.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/periph_arb_rr_pick.sv
// Rotate-priority picker: returns the first set bit of valid at or after
// rr_ptr, wrapping modulo NUM_REQ.
module periph_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand_s;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= int'(NUM_REQ)) ? (sum - int'(NUM_REQ)) : sum;
    return IW'(sum);
  endfunction

  // Walk offsets from farthest to nearest so the nearest valid entry wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand_s = wrap_idx(rr_ptr, i);
      found  = found | valid[cand_s];
      idx    = valid[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing one register bus between NUM_REQ requesters.
// Optional BUSY-state abort is enabled by defining PERIPH_ARB_TIMEOUT_EN.
module periph_reg_arbiter
  import reg_pkg::*;
  import periph_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  reg_req_t                   slv_req_i [NUM_REQ],
  output reg_rsp_t                   slv_rsp_o [NUM_REQ],
  output reg_req_t                   mst_req_o,
  input  reg_rsp_t                   mst_rsp_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       timeout_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("periph_reg_arbiter: NUM_REQ must be 2..8");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("periph_reg_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_e         state_r;
  logic [IW-1:0]      owner_r;
  logic [IW-1:0]      rr_ptr_r;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_found_s;
  logic [NUM_REQ-1:0] valid_vec_s;
  reg_req_t           own_req_s;
  logic               own_valid_s;
  logic               busy_s;
  logic               done_s;
  logic               abort_s;

  // Collect the requester valid bits for the picker.
  always_comb begin
    valid_vec_s = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      valid_vec_s[k] = slv_req_i[k].valid;
    end
  end

  periph_arb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .valid  (valid_vec_s),
    .rr_ptr (rr_ptr_r),
    .idx    (pick_idx_s),
    .found  (pick_found_s)
  );

  assign busy_s      = (state_r == BUSY);
  assign own_req_s   = slv_req_i[owner_r];
  assign own_valid_s = own_req_s.valid;
  // An abort cannot coincide with ready, so this matches mst valid && ready.
  assign done_s      = busy_s && own_valid_s && mst_rsp_i.ready;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] tmo_cnt_r;

  // Count BUSY cycles from zero for each granted transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == IDLE) && pick_found_s) begin
      tmo_cnt_r <= 16'd0;
    end else if (busy_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign abort_s = busy_s && own_valid_s && !mst_rsp_i.ready && (tmo_cnt_r == TMO_LAST);
`else
  assign abort_s = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, release on completion, abort or owner drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r <= BUSY;
            owner_r <= pick_idx_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (done_s || abort_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= IW'(rr_next(32'(owner_r), NUM_REQ));
          end else if (!own_valid_s) begin
            // Protocol violation: abandon silently, pointer left in place.
            state_r <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Route the owner onto the shared bus; everyone else sees an idle response.
  always_comb begin
    mst_req_o = '0;
    timeout_o = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      slv_rsp_o[k] = '0;
    end
    if (busy_s) begin
      mst_req_o       = own_req_s;
      mst_req_o.valid = own_valid_s && !abort_s;
      timeout_o       = abort_s;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (IW'(k) == owner_r) begin
          if (abort_s) begin
            slv_rsp_o[k] = '{rdata: 32'h0000_0000, error: 1'b1, ready: 1'b1};
          end else if (own_valid_s) begin
            slv_rsp_o[k] = mst_rsp_i;
          end else begin
            slv_rsp_o[k] = '0;
          end
        end else begin
          slv_rsp_o[k] = '0;
        end
      end
    end else begin
      mst_req_o = '0;
    end
  end

  assign busy_o  = busy_s;
  assign owner_o = owner_r;

endmodule

// File: doc/periph_reg_arbiter.md
PERIPH_REG_ARBITER -- requirements
Module: periph_reg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of reg-bus requesters; legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY-state cycle limit before abort; legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port slv_req_i, input, reg_pkg::reg_req_t [NUM_REQ]: requester buses (addr, write, wdata, wstrb, valid).
REQ-006 SHALL have port slv_rsp_o, output, reg_pkg::reg_rsp_t [NUM_REQ]: requester responses (rdata, error, ready).
REQ-007 SHALL have port mst_req_o, output, reg_pkg::reg_req_t: shared bus toward the peripheral address decoder and demux.
REQ-008 SHALL have port mst_rsp_i, input, reg_pkg::reg_rsp_t: shared-bus response.
REQ-009 SHALL have port busy_o, output, 1: high while in BUSY.
REQ-010 SHALL have port owner_o, output, $clog2(NUM_REQ): index of the current or last owner.
REQ-011 SHALL have port timeout_o, output, 1: one-cycle pulse on abort.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY.
REQ-013 In IDLE, SHALL drive mst_req_o.valid=0 and all slv_rsp_o.ready=0.
REQ-014 In IDLE with any slv_req_i[k].valid, SHALL round-robin select the first valid index at or after rr_ptr (mod NUM_REQ), latch it as owner, and enter BUSY next cycle.
REQ-015 In BUSY, SHALL pass mst_req_o=slv_req_i[owner] and slv_rsp_o[owner]=mst_rsp_i combinationally.
REQ-016 In BUSY, SHALL drive ready=0, error=0 and rdata=0 on all non-owner responses.
REQ-017 Transaction end SHALL be BUSY with mst_req_o.valid && mst_rsp_i.ready; next state IDLE, rr_ptr=(owner+1) mod NUM_REQ.
REQ-018 Minimum latency SHALL be 2 cycles from requester valid to ready: 1 arbitration cycle plus 1 zero-wait slave cycle; throughput 1 transaction per 2 cycles.
REQ-019 If the owner drops valid in BUSY before ready (protocol violation), SHALL return to IDLE next cycle, keep rr_ptr unchanged, and produce no response.
REQ-020 Requests arriving while in BUSY SHALL wait; requesters must hold valid and payload stable until ready.
REQ-021 With a single requester active, SHALL grant it every arbitration cycle regardless of rr_ptr.
REQ-022 owner_o SHALL hold its value through IDLE until the next grant.

Reset
REQ-023 On rst_ni low, asynchronously, SHALL set state=IDLE, owner=0, rr_ptr=0 and the timeout counter to 0.
REQ-024 Reset values SHALL be busy_o=0, owner_o=0, timeout_o=0, mst_req_o all zero, and slv_rsp_o all zero.
REQ-025 Reset asserted mid-transaction SHALL abandon it with no response.

Configuration
REQ-026 Macro PERIPH_ARB_TIMEOUT_EN SHALL control the abort feature as follows.
REQ-027 With the macro defined: a 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without end.
REQ-028 With the macro defined, in the cycle the counter equals TIMEOUT_CYCLES-1 with no ready: SHALL drive mst_req_o.valid=0 and slv_rsp_o[owner] with ready=1, error=1, rdata=0.
REQ-029 With the macro defined, on abort: SHALL pulse timeout_o for that cycle, go to IDLE, and advance rr_ptr.
REQ-030 With the macro defined, if ready and the limit coincide, the normal completion SHALL win and no timeout occurs.
REQ-031 Without the macro: no counter, BUSY waits indefinitely, timeout_o tied to 0.

Structure
REQ-032 Package periph_arb_pkg SHALL hold the state enum arb_state_e {IDLE, BUSY} and the TIMEOUT_CYCLES default constant.
REQ-033 SHALL contain one sub-module, periph_arb_rr_pick: a combinational rotate-priority picker with inputs valid vector and rr_ptr, outputs index and found.

Verification
REQ-034 Single requester: req0 read 0x0000_0010 with zero-wait slave returning 0xCAFE_0001 -> req0 ready in cycle 2 with rdata 0xCAFE_0001; owner_o=0.
REQ-035 Contention: req0 and req1 both valid at reset exit with rr_ptr=0 -> grant order 0,1,0,1 over four back-to-back transactions.
REQ-036 Wait states: slave ready after 5 cycles -> busy_o high 5 cycles; non-owner ready stays 0 throughout.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=8): slave never ready -> in the 8th BUSY cycle, owner ready=1, error=1, timeout_o pulses, next grant goes to the other requester.
REQ-038 Reset mid-BUSY: rst_ni low for 1 cycle at cycle 3 of a transaction -> all outputs zero immediately; no response issued after release.
REQ-039 Owner drops valid in BUSY -> IDLE next cycle, rr_ptr unchanged, no ready to any requester.
